// File: rtl/vga_prefetch_ctrl_if.sv
// Command, readout and output-FIFO signals between the VGA prefetch controller,
// the SDRAM arbiter and the pixel FIFO.
interface vga_prefetch_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [24:0] cmd_addr;
  logic        rd_valid;
  logic [24:0] rd_addr;
  logic [15:0] rd_data;
  logic        out_wrreq;
  logic [15:0] out_data;
  logic [7:0]  out_usedw;

  modport master (
    output cmd_valid, cmd_addr, out_wrreq, out_data,
    input  cmd_ready, rd_valid, rd_addr, rd_data, out_usedw
  );

  modport slave (
    input  cmd_valid, cmd_addr, out_wrreq, out_data,
    output cmd_ready, rd_valid, rd_addr, rd_data, out_usedw
  );
endinterface

// File: rtl/vga_prefetch_ctrl.sv
// VGA read-path prefetcher: issues in-order frame reads under a credit limit,
// matches returned data by address and keeps the pixel FIFO fed.
module vga_prefetch_ctrl #(
  parameter int unsigned FRAME_PIXELS    = 307200,
  parameter int unsigned FIFO_DEPTH      = 256,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned LOW_WATER       = 2,
  parameter int unsigned FILL_LEVEL      = 128,
  parameter logic [15:0] NULL_COLOR      = 16'hE81F
) (
  input  logic                clk,
  input  logic                portV_arst,
  input  logic                enable,
  input  logic [24:0]         frame_base,
  vga_prefetch_ctrl_if.master bus,
  output logic                frame_start,
  output logic [15:0]         null_count,
  output logic                busy
);

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;
  localparam int unsigned UW = 8;
  localparam int unsigned CW = 10;
  localparam int unsigned IW = $clog2(FRAME_PIXELS);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   req_idx_q, req_idx_d;
  logic [IW-1:0]   exp_idx_q, exp_idx_d;
  logic [AW-1:0]   req_base_q, req_base_d;
  logic [AW-1:0]   exp_base_q, exp_base_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [DW-1:0]   null_count_q, null_count_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_wrreq_q, out_wrreq_d;
  logic            frame_start_q, frame_start_d;

  logic            issuing_c, cmd_valid_c, accept_c;
  logic            in_win_c, hit_c, null_c, adv_req_c, adv_exp_c;
  logic [CW-1:0]   credit_c;
  logic [AW:0]     rd_off_c;

  // Issue side: credit covers both unreturned reads and words already in the FIFO
  assign issuing_c   = (state_q == ST_FILL) || (state_q == ST_STREAM);
  assign credit_c    = CW'(bus.out_usedw) + CW'(outstanding_q);
  assign cmd_valid_c = issuing_c && (outstanding_q < OW'(MAX_OUTSTANDING))
                       && (credit_c < CW'(FIFO_DEPTH - 4));
  assign accept_c    = cmd_valid_c && bus.cmd_ready;

  // Return side: offset into the current frame window, borrow bit marks below-window
  assign rd_off_c  = {1'b0, bus.rd_addr} - {1'b0, exp_base_q};
  assign in_win_c  = bus.rd_valid && (state_q != ST_IDLE) && !rd_off_c[AW]
                     && (rd_off_c[AW-1:0] < AW'(FRAME_PIXELS));
  assign hit_c     = in_win_c && (rd_off_c[AW-1:0] == AW'(exp_idx_q));
  assign null_c    = (state_q == ST_STREAM) && !hit_c
                     && (bus.out_usedw <= UW'(LOW_WATER));
  assign adv_exp_c = hit_c || null_c;
  // A nulled pixel that was never requested is skipped on the request side too
  assign adv_req_c = accept_c || (null_c && (exp_idx_q == req_idx_q));

  always_comb begin
    state_d       = state_q;
    req_idx_d     = req_idx_q;
    exp_idx_d     = exp_idx_q;
    req_base_d    = req_base_q;
    exp_base_d    = exp_base_q;
    outstanding_d = outstanding_q;
    null_count_d  = null_count_q;
    out_data_d    = out_data_q;
    out_wrreq_d   = 1'b0;
    frame_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_FILL;
          req_base_d = frame_base;
          exp_base_d = frame_base;
          req_idx_d  = '0;
          exp_idx_d  = '0;
        end
      end
      ST_FILL: begin
        if (!enable) begin
          state_d = ST_DRAIN;
        end else if (CW'(bus.out_usedw) >= CW'(FILL_LEVEL)) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (!enable) begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        if (outstanding_q == '0) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    if (adv_req_c) begin
      if (req_idx_q == IW'(FRAME_PIXELS - 1)) begin
        req_idx_d  = '0;
        req_base_d = frame_base;
      end else begin
        req_idx_d = req_idx_q + IW'(1);
      end
    end

    if (adv_exp_c) begin
      out_wrreq_d = 1'b1;
      out_data_d  = hit_c ? bus.rd_data : NULL_COLOR;
      if (exp_idx_q == IW'(FRAME_PIXELS - 1)) begin
        frame_start_d = 1'b1;
        exp_idx_d     = '0;
        exp_base_d    = req_base_q;
      end else begin
        exp_idx_d = exp_idx_q + IW'(1);
      end
    end

    if (null_c && (null_count_q != '1)) begin
      null_count_d = null_count_q + DW'(1);
    end

    if (accept_c && !in_win_c) begin
      outstanding_d = outstanding_q + OW'(1);
    end else if (!accept_c && in_win_c && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) begin
      state_q       <= ST_IDLE;
      req_idx_q     <= '0;
      exp_idx_q     <= '0;
      req_base_q    <= '0;
      exp_base_q    <= '0;
      outstanding_q <= '0;
      null_count_q  <= '0;
      out_data_q    <= '0;
      out_wrreq_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_idx_q     <= req_idx_d;
      exp_idx_q     <= exp_idx_d;
      req_base_q    <= req_base_d;
      exp_base_q    <= exp_base_d;
      outstanding_q <= outstanding_d;
      null_count_q  <= null_count_d;
      out_data_q    <= out_data_d;
      out_wrreq_q   <= out_wrreq_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.cmd_valid = cmd_valid_c;
  assign bus.cmd_addr  = req_base_q + AW'(req_idx_q);
  assign bus.out_wrreq = out_wrreq_q;
  assign bus.out_data  = out_data_q;
  assign frame_start   = frame_start_q;
  assign null_count    = null_count_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
